// File: rtl/diagv2_ecall_handler_if.sv
// Memory read port and console byte channel of the ecall handler.
// master: handler side (mem_req/mem_addr/tx_*), slave: memory + console.
interface diagv2_ecall_handler_if #(
  parameter int ADDR_BITS = 32
);
  logic                 mem_req;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [7:0]           mem_rdata;
  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (
    output mem_req, mem_addr, tx_data, tx_valid,
    input  mem_rdata, tx_ready
  );

  modport slave (
    input  mem_req, mem_addr, tx_data, tx_valid,
    output mem_rdata, tx_ready
  );
endinterface

// File: rtl/diagv2_ecall_handler.sv
// Hardware ecall responder: freezes the core, runs EXIT/WRITE, else ENOSYS.
// Ports: clk/reset, ecall + a7/a0/a1/a2 in, stall/resume/rd_* and halt/exit_code/invalid_ecall out, bus = mem + console.
module diagv2_ecall_handler #(
  parameter int DATA_BITS     = 64,
  parameter int ADDR_BITS     = 32,
  parameter int MAX_WRITE_LEN = 4096
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ecall,
  input  logic [DATA_BITS-1:0] a7_sys,
  input  logic [DATA_BITS-1:0] a0_arg,
  input  logic [DATA_BITS-1:0] a1_arg,
  input  logic [DATA_BITS-1:0] a2_arg,
  output logic                 stall,
  output logic                 resume,
  output logic                 rd_we,
  output logic [DATA_BITS-1:0] rd_wdata,
  output logic                 halt,
  output logic [DATA_BITS-1:0] exit_code,
  output logic                 invalid_ecall,
  diagv2_ecall_handler_if.master bus
);

  localparam int CW = $clog2(MAX_WRITE_LEN + 1);

  localparam logic [DATA_BITS-1:0] SYS_EXIT  = DATA_BITS'(93);
  localparam logic [DATA_BITS-1:0] SYS_WRITE = DATA_BITS'(64);
  localparam logic [DATA_BITS-1:0] RET_EBADF = DATA_BITS'(-9);
  localparam logic [DATA_BITS-1:0] RET_NOSYS = DATA_BITS'(-38);
  localparam logic [DATA_BITS-1:0] MAX_LEN   = DATA_BITS'(MAX_WRITE_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_FETCH,
    S_WAIT,
    S_SEND,
    S_RETURN,
    S_RELEASE,
    S_HALTED
  } state_t;

  state_t state, state_nx;

  logic [DATA_BITS-1:0] sys_q;
  logic [DATA_BITS-1:0] fd_q;
  logic [DATA_BITS-1:0] buf_q;
  logic [DATA_BITS-1:0] len_q;
  logic [DATA_BITS-1:0] ret_q;
  logic [DATA_BITS-1:0] exit_q;
  logic [CW-1:0]        cnt_q;
  logic [CW-1:0]        idx_q;
  logic [7:0]           tx_q;

  logic is_exit;
  logic is_write;
  logic fd_ok;
  logic len_zero;
  logic last_byte;

  assign is_exit   = (sys_q == SYS_EXIT);
  assign is_write  = (sys_q == SYS_WRITE);
  assign fd_ok     = (fd_q == DATA_BITS'(1)) ||
                     (fd_q == DATA_BITS'(2));
  assign len_zero  = (len_q == '0);
  assign last_byte = ((idx_q + CW'(1)) == cnt_q);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:    if (ecall) state_nx = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          is_exit:  state_nx = S_HALTED;
          is_write: state_nx = (fd_ok && !len_zero) ?
                               S_FETCH : S_RETURN;
          default:  state_nx = S_RETURN;
        endcase
      end
      S_FETCH:   state_nx = S_WAIT;
      S_WAIT:    state_nx = S_SEND;
      S_SEND: begin
        if (bus.tx_ready)
          state_nx = last_byte ? S_RETURN : S_FETCH;
      end
      S_RETURN:  state_nx = S_RELEASE;
      // A still-high ecall belongs to the call just serviced.
      S_RELEASE: if (!ecall) state_nx = S_IDLE;
      S_HALTED:  state_nx = S_HALTED;
      default:   state_nx = S_IDLE;
    endcase
  end

  // Call context and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      sys_q  <= '0;
      fd_q   <= '0;
      buf_q  <= '0;
      len_q  <= '0;
      ret_q  <= '0;
      exit_q <= '0;
      cnt_q  <= '0;
      idx_q  <= '0;
      tx_q   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (ecall) begin
            sys_q <= a7_sys;
            fd_q  <= a0_arg;
            buf_q <= a1_arg;
            len_q <= a2_arg;
          end
        end
        S_DECODE: begin
          unique case (1'b1)
            is_exit: exit_q <= fd_q;
            is_write: begin
              if (!fd_ok)        ret_q <= RET_EBADF;
              else if (len_zero) ret_q <= '0;
              else begin
                cnt_q <= (len_q > MAX_LEN) ?
                         CW'(MAX_WRITE_LEN) : CW'(len_q);
                idx_q <= '0;
              end
            end
            default: ret_q <= RET_NOSYS;
          endcase
        end
        S_WAIT: tx_q <= bus.mem_rdata;
        S_SEND: begin
          if (bus.tx_ready) begin
            idx_q <= idx_q + CW'(1);
            if (last_byte) ret_q <= DATA_BITS'(cnt_q);
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    stall         = ecall || (state != S_IDLE);
    resume        = (state == S_RETURN);
    rd_we         = (state == S_RETURN);
    rd_wdata      = (state == S_RETURN) ? ret_q : '0;
    halt          = (state == S_HALTED);
    exit_code     = exit_q;
    invalid_ecall = (state == S_DECODE) && !is_exit && !is_write;
    bus.mem_req   = (state == S_FETCH);
    // Address wraps modulo 2^ADDR_BITS.
    bus.mem_addr  = (state == S_FETCH) ?
                    ADDR_BITS'(buf_q + DATA_BITS'(idx_q)) : '0;
    bus.tx_valid  = (state == S_SEND);
    bus.tx_data   = tx_q;
  end

endmodule

// File: tb/tb_diagv2_ecall_handler.sv
// Directed bench for diagv2_ecall_handler with mem model and scoreboards.
// Expected addresses, bytes and return values are queued, then popped by monitors.
module tb_diagv2_ecall_handler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ecall = 1'b0;
  logic [63:0] a7_sys = '0;
  logic [63:0] a0_arg = '0;
  logic [63:0] a1_arg = '0;
  logic [63:0] a2_arg = '0;
  logic        stall, resume, rd_we, halt, invalid_ecall;
  logic [63:0] rd_wdata, exit_code;

  diagv2_ecall_handler_if #(.ADDR_BITS(32)) bus ();

  diagv2_ecall_handler dut (
    .clk           (clk),
    .reset         (reset),
    .ecall         (ecall),
    .a7_sys        (a7_sys),
    .a0_arg        (a0_arg),
    .a1_arg        (a1_arg),
    .a2_arg        (a2_arg),
    .stall         (stall),
    .resume        (resume),
    .rd_we         (rd_we),
    .rd_wdata      (rd_wdata),
    .halt          (halt),
    .exit_code     (exit_code),
    .invalid_ecall (invalid_ecall),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int resume_cnt = 0;
  int inv_cnt = 0;

  logic [7:0]  mem [0:1023];
  logic [31:0] exp_addr[$];
  logic [7:0]  exp_tx[$];
  logic [63:0] exp_ret[$];

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Byte memory: data valid the cycle after mem_req.
  initial bus.mem_rdata = '0;
  always @(posedge clk)
    if (bus.mem_req) bus.mem_rdata <= mem[bus.mem_addr[9:0]];

  // Scoreboard monitors, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.mem_req) begin
        check("addr_expected", 64'(exp_addr.size() != 0), 64'd1);
        if (exp_addr.size() != 0)
          check("mem_addr", 64'(bus.mem_addr), 64'(exp_addr.pop_front()));
      end
      if (bus.tx_valid && bus.tx_ready) begin
        check("tx_expected", 64'(exp_tx.size() != 0), 64'd1);
        if (exp_tx.size() != 0)
          check("tx_data", 64'(bus.tx_data), 64'(exp_tx.pop_front()));
      end
      if (resume) begin
        resume_cnt++;
        check("rd_we", 64'(rd_we), 64'd1);
        check("ret_expected", 64'(exp_ret.size() != 0), 64'd1);
        if (exp_ret.size() != 0)
          check("rd_wdata", rd_wdata, exp_ret.pop_front());
      end
      if (invalid_ecall) inv_cnt++;
    end
  end

  // Issue a call, hold ecall `hold` cycles past resume, return latency.
  task automatic call(input logic [63:0] s, f, b, l,
                      input int hold, output int lat);
    int r0;
    r0 = resume_cnt;
    a7_sys = s; a0_arg = f; a1_arg = b; a2_arg = l;
    ecall = 1'b1;
    lat = 0;
    do begin
      tick();
      lat++;
      if (lat == 1) begin
        a0_arg = 64'hDEAD; a1_arg = 64'h3F0; a2_arg = 64'h77;
      end
    end while (!resume && lat < 200);
    check("resume_seen", 64'(resume), 64'd1);
    repeat (hold) tick();
    ecall = 1'b0;
    tick();
    tick();
    check("stall_released", 64'(stall), 64'd0);
    check("one_resume", 64'(resume_cnt - r0), 64'd1);
  endtask

  initial begin
    int lat, r0, n;
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i);
    bus.tx_ready = 1'b1;

    // Reset state
    tick(); tick();
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_resume", 64'(resume), 64'd0);
    check("rst_rd_we", 64'(rd_we), 64'd0);
    check("rst_rd_wdata", rd_wdata, 64'd0);
    check("rst_mem_req", 64'(bus.mem_req), 64'd0);
    check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    check("rst_tx_valid", 64'(bus.tx_valid), 64'd0);
    check("rst_tx_data", 64'(bus.tx_data), 64'd0);
    check("rst_halt", 64'(halt), 64'd0);
    check("rst_exit_code", exit_code, 64'd0);
    check("rst_invalid", 64'(invalid_ecall), 64'd0);
    reset = 1'b0;
    tick();

    // EXIT(0): halt two cycles later, then ecall is ignored
    a7_sys = 64'd93; a0_arg = 64'd0; ecall = 1'b1;
    #1;
    check("exit_stall_comb", 64'(stall), 64'd1);
    tick();
    check("exit_halt_early", 64'(halt), 64'd0);
    tick();
    check("exit_halt", 64'(halt), 64'd1);
    check("exit_code0", exit_code, 64'd0);
    for (int i = 0; i < 6; i++) begin
      ecall = i[0];
      tick();
    end
    ecall = 1'b0;
    tick();
    check("halt_sticky", 64'(halt), 64'd1);
    check("halt_stall", 64'(stall), 64'd1);
    check("halt_no_resume", 64'(resume_cnt), 64'd0);
    check("halt_no_invalid", 64'(inv_cnt), 64'd0);
    reset = 1'b1; tick(); reset = 1'b0;
    check("halt_cleared", 64'(halt), 64'd0);

    // EXIT(3), then reset
    a7_sys = 64'd93; a0_arg = 64'd3; ecall = 1'b1;
    tick(); tick();
    check("exit3_halt", 64'(halt), 64'd1);
    check("exit3_code", exit_code, 64'd3);
    ecall = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    check("exit3_rst_halt", 64'(halt), 64'd0);
    check("exit3_rst_code", exit_code, 64'd0);
    check("exit3_rst_stall", 64'(stall), 64'd0);

    // WRITE "Hi" with back-pressure on the first byte
    mem[10'h100] = 8'h48; mem[10'h101] = 8'h69;
    exp_addr.push_back(32'h100); exp_addr.push_back(32'h101);
    exp_tx.push_back(8'h48); exp_tx.push_back(8'h69);
    exp_ret.push_back(64'd2);
    r0 = resume_cnt;
    bus.tx_ready = 1'b0;
    a7_sys = 64'd64; a0_arg = 64'd1; a1_arg = 64'h100; a2_arg = 64'd2;
    ecall = 1'b1;
    n = 0;
    do begin
      tick(); n++;
      check("wr_stall", 64'(stall), 64'd1);
    end while (!bus.tx_valid && n < 20);
    for (int i = 0; i < 3; i++) begin
      check("wr_hold_valid", 64'(bus.tx_valid), 64'd1);
      check("wr_hold_data", 64'(bus.tx_data), 64'h48);
      tick();
    end
    bus.tx_ready = 1'b1;
    n = 0;
    while (!resume && n < 30) begin
      check("wr_stall2", 64'(stall), 64'd1);
      tick(); n++;
    end
    check("wr_resume", 64'(resume), 64'd1);
    ecall = 1'b0;
    tick(); tick();
    check("wr_one_resume", 64'(resume_cnt - r0), 64'd1);
    check("wr_released", 64'(stall), 64'd0);

    // Latency: 1-byte WRITE = 5, 2-byte wrapping WRITE = 8
    mem[10'h200] = 8'h5A;
    exp_addr.push_back(32'h200); exp_tx.push_back(8'h5A);
    exp_ret.push_back(64'd1);
    call(64'd64, 64'd2, 64'h200, 64'd1, 0, lat);
    check("lat_write1", 64'(lat), 64'd5);
    mem[10'h3FF] = 8'h11; mem[10'h000] = 8'h22;
    exp_addr.push_back(32'hFFFF_FFFF); exp_addr.push_back(32'h0);
    exp_tx.push_back(8'h11); exp_tx.push_back(8'h22);
    exp_ret.push_back(64'd2);
    call(64'd64, 64'd1, 64'hFFFF_FFFF, 64'd2, 0, lat);
    check("lat_write_wrap", 64'(lat), 64'd8);

    // WRITE len=0, bad fd
    exp_ret.push_back(64'd0);
    call(64'd64, 64'd1, 64'h100, 64'd0, 0, lat);
    check("lat_len0", 64'(lat), 64'd2);
    exp_ret.push_back(64'hFFFF_FFFF_FFFF_FFF7);
    call(64'd64, 64'd5, 64'h100, 64'd4, 0, lat);
    check("lat_badfd", 64'(lat), 64'd2);

    // Unsupported syscall with ecall lingering past resume
    r0 = inv_cnt;
    exp_ret.push_back(64'hFFFF_FFFF_FFFF_FFDA);
    call(64'd57, 64'd0, 64'd0, 64'd0, 3, lat);
    check("lat_enosys", 64'(lat), 64'd2);
    check("invalid_pulse", 64'(inv_cnt - r0), 64'd1);

    // Reset during SEND abandons the string
    bus.tx_ready = 1'b0;
    exp_addr.push_back(32'h300);
    a7_sys = 64'd64; a0_arg = 64'd1; a1_arg = 64'h300; a2_arg = 64'd3;
    ecall = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!bus.tx_valid && n < 20);
    check("mid_send_valid", 64'(bus.tx_valid), 64'd1);
    reset = 1'b1;
    tick();
    check("rst_send_valid", 64'(bus.tx_valid), 64'd0);
    check("rst_send_stall_hi", 64'(stall), 64'd1);
    ecall = 1'b0;
    #1;
    check("rst_send_stall_lo", 64'(stall), 64'd0);
    tick();
    reset = 1'b0;
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst_valid", 64'(bus.tx_valid), 64'd0);
    end

    check("addr_q_empty", 64'(exp_addr.size()), 64'd0);
    check("tx_q_empty", 64'(exp_tx.size()), 64'd0);
    check("ret_q_empty", 64'(exp_ret.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/diagv2_ecall_handler.md
Name: diagv2_ecall_handler

Overview:
- Synthesizable environment-call responder for the diagv2 pipelined core; services the core's `ecall` request in hardware.
- Freezes the core, decodes the syscall number in a7, and performs one of three actions:
  - EXIT (93): latch status and halt.
  - WRITE (64): stream bytes from data memory to a console byte channel, then return a0.
  - Anything else: return ENOSYS.
- Sits beside the core and dmem in the top level; lets hardware runs end and report status without bench-side hierarchical peeking.

Parameters:
- DATA_BITS, 64, width of the register arguments and the return value.
- ADDR_BITS, 32, width of the byte address on the memory read port.
- MAX_WRITE_LEN, 4096, cap on bytes transferred per WRITE call.

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  synchronous, active-high.
- ecall  in  1  level request from core; held high until the cycle after resume.
- a7_sys  in  DATA_BITS  syscall number (x17).
- a0_arg  in  DATA_BITS  x10 (exit code / fd).
- a1_arg  in  DATA_BITS  x11 (buffer address).
- a2_arg  in  DATA_BITS  x12 (length).
- stall  out  1  freeze core pipeline.
- resume  out  1  one-cycle pulse: call complete.
- rd_we  out  1  write rd_wdata into x10; coincident with resume.
- rd_wdata  out  DATA_BITS  syscall return value.
- mem_req  out  1  byte read request.
- mem_addr  out  ADDR_BITS  byte address.
- mem_rdata  in  8  read byte, valid exactly 1 cycle after mem_req.
- tx_data  out  8  console byte.
- tx_valid  out  1  console byte valid.
- tx_ready  in  1  console accepts byte.
- halt  out  1  EXIT taken; sticky until reset.
- exit_code  out  DATA_BITS  a0 captured at EXIT.
- invalid_ecall  out  1  one-cycle pulse on an unsupported syscall.

Behaviour:
- Reset (synchronous) forces state IDLE and clears all registered outputs: stall=0 apart from the combinational ecall term, resume=0, rd_we=0, rd_wdata=0, mem_req=0, mem_addr=0, tx_valid=0, tx_data=0, halt=0, exit_code=0, invalid_ecall=0.
- Reset wins over every other event, including mid-WRITE. A partially sent string is abandoned with no further tx_valid.
- stall = ecall | (state != IDLE). Combinational, so the core freezes in the same cycle ecall rises.
- States: IDLE, DECODE, FETCH, WAIT, SEND, RETURN, RELEASE, HALTED.
- IDLE: on ecall=1, capture a7/a0/a1/a2 and go to DECODE.
- DECODE:
  - sys=93: exit_code<=a0 and go to HALTED.
  - sys=64:
    - fd not 1 or 2: ret=-9, go to RETURN.
    - len==0: ret=0, go to RETURN.
    - otherwise: cnt=min(len, MAX_WRITE_LEN), idx=0, go to FETCH.
  - any other sys: ret=-38, invalid_ecall pulses, go to RETURN.
- FETCH: mem_req=1 for one cycle, mem_addr=(a1+idx) mod 2^ADDR_BITS (wrap-around allowed); go to WAIT.
- WAIT: latch mem_rdata into tx_data; go to SEND.
- SEND:
  - tx_valid=1, tx_data held stable until tx_ready=1.
  - On the handshake cycle: idx++.
  - If idx+1==cnt: ret=cnt, go to RETURN. Else go to FETCH.
- RETURN: resume=1, rd_we=1, rd_wdata=ret (sign-extended to DATA_BITS) for exactly one cycle; go to RELEASE.
- RELEASE: stall stays high; go to IDLE only when ecall==0. A lingering ecall is never re-serviced.
- HALTED:
  - halt=1 and stall=1 forever.
  - ecall is ignored; no resume, rd_we or invalid_ecall.
  - Only reset exits.
- Latency with tx_ready tied high:
  - non-WRITE return: resume 2 cycles after ecall is sampled.
  - WRITE of N bytes: resume 3N+2 cycles after ecall is sampled.
  - EXIT: halt rises 2 cycles after ecall is sampled.
- Arguments are sampled only in IDLE; a0–a2 changing later have no effect.

Test Plan:
- a7=93, a0=0 -> halt=1 two cycles later, exit_code=0, resume never pulses; further ecall pulses ignored.
- a7=93, a0=3 -> exit_code=3; reset high 1 cycle -> halt=0, state IDLE.
- a7=64, a0=1, a1=0x100, a2=2, bytes 0x48 0x69, tx_ready low for 3 cycles on the first byte:
  - tx stream is 0x48 then 0x69; mem_addr 0x100 then 0x101.
  - resume with rd_wdata=2; stall high throughout.
- a7=64, a2=0 -> no mem_req, no tx_valid, rd_wdata=0.
- a7=64, a0=5 -> rd_wdata=0xFFFF_FFFF_FFFF_FFF7.
- a7=57 -> invalid_ecall one pulse, rd_wdata=-38.
- ecall held 3 cycles past resume -> exactly one resume.
- Reset asserted during SEND -> tx_valid=0 and stall follows ecall only.
